// File: rtl/aud_pcm_refill_ctl.sv
// ---------------------------------------------------------------------------------------------
// aud_pcm_refill_ctl
//
// Refill sequencer for the PCM sample ring (2^IDX_BITS entries of 64-bit blocks). It tracks how
// far its write index is ahead of the device play index. When that gap leaves room, it fetches
// the next source block from memory and writes the block into the ring. The memory port allows
// only one request in flight. The source can be one-shot or looping, and the block pulses
// irqDone each time the source reaches its end.
//
// Ports
//   clock, reset      system clock (rising edge) and asynchronous active-low reset
//   cfgEnable         run enable; a 0->1 edge starts a transfer, 0 aborts/returns to idle
//   cfgBaseAddr       source byte address (bits [2:0] ignored), latched at start
//   cfgLenBlk         source length in 64-bit blocks, latched at start
//   cfgLoop           1 = wrap source to base at end, latched at start
//   playIdx           ring index the PCM device is currently reading
//   memReq*           block fetch request (valid/ready, address held stable while pending)
//   memRsp*           one-cycle response strobe with the fetched block
//   bufWr*            ring write port, one strobe per block
//   irqDone           one-cycle pulse at source end (wrap or stop)
//   busy              high in all states except idle and done
//   fillLevel         registered (wrIdx - playIdx) mod 2^IDX_BITS
// ---------------------------------------------------------------------------------------------
module aud_pcm_refill_ctl #(
  parameter int unsigned IDX_BITS = 10,
  parameter int unsigned GUARD    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfgEnable,
  input  logic [31:0]         cfgBaseAddr,
  input  logic [15:0]         cfgLenBlk,
  input  logic                cfgLoop,
  input  logic [IDX_BITS-1:0] playIdx,
  output logic [31:0]         memReqAddr,
  output logic                memReqValid,
  input  logic                memReqReady,
  input  logic [63:0]         memRspData,
  input  logic                memRspValid,
  output logic [IDX_BITS-1:0] bufWrIdx,
  output logic [63:0]         bufWrData,
  output logic                bufWrEn,
  output logic                irqDone,
  output logic                busy,
  output logic [IDX_BITS-1:0] fillLevel
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StReq   = 3'd2,
    StWait  = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } state_e;

  // A fetch is only issued while the level is below ring size minus the guard gap, so the
  // writer never catches up with the block the device is reading.
  localparam int unsigned          LimitInt   = (32'd1 << IDX_BITS) - GUARD;
  localparam logic [IDX_BITS:0]    LevelLimit = LimitInt[IDX_BITS:0];
  localparam logic [IDX_BITS-1:0]  IdxOne     = IDX_BITS'(1);

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] wr_idx_q, wr_idx_d;
  logic [15:0]         src_pos_q, src_pos_d;
  logic [31:0]         base_q, base_d;
  logic [15:0]         len_q, len_d;
  logic                loop_q, loop_d;
  logic                discard_q, discard_d;
  logic                en_q;
  logic [31:0]         addr_q, addr_d;
  logic [63:0]         data_q, data_d;
  logic [IDX_BITS-1:0] fill_q, fill_d;
  logic                irq_start_q, irq_start_d;
  logic                irq_wr;

  logic [IDX_BITS-1:0] level;
  logic                room;
  logic [15:0]         src_next;
  logic                start;

  // Low address bits are forced to zero, so they are never consumed.
  logic unused_base_lsb;
  assign unused_base_lsb = ^cfgBaseAddr[2:0];

  assign level    = wr_idx_q - playIdx;
  assign room     = {1'b0, level} < LevelLimit;
  assign src_next = src_pos_q + 16'd1;
  assign start    = cfgEnable && !en_q;
  assign fill_d   = level;

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    src_pos_d   = src_pos_q;
    base_d      = base_q;
    len_d       = len_q;
    loop_d      = loop_q;
    discard_d   = discard_q;
    addr_d      = addr_q;
    data_d      = data_q;
    irq_start_d = 1'b0;
    irq_wr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d    = {cfgBaseAddr[31:3], 3'b000};
          len_d     = cfgLenBlk;
          loop_d    = cfgLoop;
          src_pos_d = '0;
          wr_idx_d  = playIdx;
          discard_d = 1'b0;
          if (cfgLenBlk == 16'd0) begin
            // Empty source completes immediately; the pulse is registered so it appears in
            // the first DONE cycle.
            state_d     = StDone;
            irq_start_d = 1'b1;
          end else begin
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        if (!cfgEnable) begin
          state_d = StIdle;
        end else if (room) begin
          state_d = StReq;
          addr_d  = base_q + {13'd0, src_pos_q, 3'b000};
        end
      end

      StReq: begin
        // The request cannot be withdrawn once raised; an abort only marks the block for
        // discard.
        if (!cfgEnable) begin
          discard_d = 1'b1;
        end
        if (memReqReady) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (!cfgEnable) begin
          discard_d = 1'b1;
        end
        if (memRspValid) begin
          if (discard_q || !cfgEnable) begin
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            data_d  = memRspData;
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        wr_idx_d = wr_idx_q + IdxOne;
        if (src_next == len_q) begin
          irq_wr = 1'b1;
          if (loop_q) begin
            src_pos_d = '0;
            state_d   = StCheck;
          end else begin
            src_pos_d = src_next;
            state_d   = StDone;
          end
        end else begin
          src_pos_d = src_next;
          state_d   = StCheck;
        end
        // The write itself always completes; an abort only redirects the follow-up state.
        if (!cfgEnable) begin
          state_d = StIdle;
        end
      end

      StDone: begin
        if (!cfgEnable) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      src_pos_q   <= '0;
      base_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      discard_q   <= 1'b0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      fill_q      <= '0;
      irq_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      src_pos_q   <= src_pos_d;
      base_q      <= base_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      discard_q   <= discard_d;
      en_q        <= cfgEnable;
      addr_q      <= addr_d;
      data_q      <= data_d;
      fill_q      <= fill_d;
      irq_start_q <= irq_start_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign memReqValid = (state_q == StReq);
  assign memReqAddr  = addr_q;
  assign bufWrEn     = (state_q == StWrite);
  assign bufWrIdx    = wr_idx_q;
  assign bufWrData   = data_q;
  assign irqDone     = irq_start_q | irq_wr;
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign fillLevel   = fill_q;

endmodule

// File: tb/tb_aud_pcm_refill_ctl.sv
// ---------------------------------------------------------------------------------------------
// tb_aud_pcm_refill_ctl
//
// Scoreboard bench. The stimulus pushes the expected fetch addresses and the expected ring
// writes into queues. A memory model pops an address at each request handshake, and a write
// monitor pops an expected write on each bufWrEn.
// ---------------------------------------------------------------------------------------------
module tb_aud_pcm_refill_ctl;

  localparam int unsigned IdxBits = 10;

  typedef struct {
    logic [IdxBits-1:0] idx;
    logic [63:0]        data;
    logic               irq;
  } wr_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cfgEnable;
  logic [31:0]        cfgBaseAddr;
  logic [15:0]        cfgLenBlk;
  logic               cfgLoop;
  logic [IdxBits-1:0] playIdx;
  logic [31:0]        memReqAddr;
  logic               memReqValid;
  logic               memReqReady;
  logic [63:0]        memRspData;
  logic               memRspValid;
  logic [IdxBits-1:0] bufWrIdx;
  logic [63:0]        bufWrData;
  logic               bufWrEn;
  logic               irqDone;
  logic               busy;
  logic [IdxBits-1:0] fillLevel;

  aud_pcm_refill_ctl #(
    .IDX_BITS (IdxBits),
    .GUARD    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfgEnable   (cfgEnable),
    .cfgBaseAddr (cfgBaseAddr),
    .cfgLenBlk   (cfgLenBlk),
    .cfgLoop     (cfgLoop),
    .playIdx     (playIdx),
    .memReqAddr  (memReqAddr),
    .memReqValid (memReqValid),
    .memReqReady (memReqReady),
    .memRspData  (memRspData),
    .memRspValid (memRspValid),
    .bufWrIdx    (bufWrIdx),
    .bufWrData   (bufWrData),
    .bufWrEn     (bufWrEn),
    .irqDone     (irqDone),
    .busy        (busy),
    .fillLevel   (fillLevel)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  int          wr_cnt = 0;
  int          irq_cnt = 0;
  int          req_cnt = 0;
  int          busy_cnt = 0;
  int          last_run = 0;
  int          stall_req = 0;
  bit          mem_mute = 1'b0;
  bit          inject_rsp = 1'b0;
  logic [31:0] exp_addr_q[$];
  wr_t         exp_wr_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_for(input logic [31:0] addr);
    return {addr ^ 32'hDEAD_BEEF, addr + 32'h1357_9BDF};
  endfunction

  // Memory model: acts on falling edges, so every input it drives is stable at the rising edge.
  initial begin : mem_model
    logic        hs_pend;
    logic [31:0] hs_addr;
    logic [31:0] held;
    int          run;
    int          stall_left;
    hs_pend     = 1'b0;
    hs_addr     = '0;
    held        = '0;
    run         = 0;
    stall_left  = 0;
    memReqReady = 1'b0;
    memRspValid = 1'b0;
    memRspData  = '0;
    forever begin
      @(negedge clock);
      memRspValid = 1'b0;
      memReqReady = 1'b0;
      if (!reset) begin
        hs_pend = 1'b0;
        run     = 0;
      end else begin
        if (hs_pend && !mem_mute) begin
          memRspValid = 1'b1;
          memRspData  = data_for(hs_addr);
        end
        if (inject_rsp) begin
          memRspValid = 1'b1;
          memRspData  = 64'h0BAD_0BAD_0BAD_0BAD;
        end
        hs_pend = 1'b0;
        if (memReqValid) begin
          if (run == 0) begin
            held       = memReqAddr;
            stall_left = stall_req;
          end else begin
            chk("req_stable", memReqAddr, held);
          end
          run++;
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            memReqReady = 1'b1;
            hs_pend     = 1'b1;
            hs_addr     = memReqAddr;
            req_cnt++;
            last_run = run;
            run      = 0;
            if (exp_addr_q.size() == 0) chk("req_unexpected", 1, 0);
            else chk("req_addr", memReqAddr, exp_addr_q.pop_front());
          end
        end
      end
    end
  end

  // Ring-write monitor and event counters.
  initial begin : wr_monitor
    wr_t e;
    forever begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (irqDone) irq_cnt++;
      if (bufWrEn) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_idx", 64'(bufWrIdx), 64'(e.idx));
          chk("wr_data", bufWrData, e.data);
          chk("wr_irq", 64'(irqDone), 64'(e.irq));
        end
      end
    end
  end

  // Stimulus changes 2 time units after a rising edge, well away from both edges.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push_run(input logic [31:0] base, input int len, input logic [IdxBits-1:0] play,
                          input int first, input int nblk);
    wr_t         e;
    logic [31:0] a;
    int          pos;
    for (int k = first; k < first + nblk; k++) begin
      pos    = k % len;
      a      = base + 32'(pos) * 32'd8;
      exp_addr_q.push_back(a);
      e.idx  = play + IdxBits'(k);
      e.data = data_for(a);
      e.irq  = (pos == len - 1);
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] len, input logic loop);
    cfgBaseAddr = base;
    cfgLenBlk   = len;
    cfgLoop     = loop;
    cfgEnable   = 1'b1;
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (wr_cnt < target && b > 0) begin
      step(1);
      b--;
    end
    if (wr_cnt < target) chk(tag, wr_cnt, target);
  endtask

  task automatic wait_req(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (req_cnt < target && b > 0) begin
      step(1);
      b--;
    end
    if (req_cnt < target) chk(tag, req_cnt, target);
  endtask

  task automatic check_queues(input string tag);
    chk({tag, "_addr_left"}, exp_addr_q.size(), 0);
    chk({tag, "_wr_left"}, exp_wr_q.size(), 0);
  endtask

  initial begin : main
    int w0;
    int i0;
    int r0;
    int b0;
    int bound;
    cfgEnable   = 1'b0;
    cfgBaseAddr = '0;
    cfgLenBlk   = '0;
    cfgLoop     = 1'b0;
    playIdx     = '0;
    #3 reset = 1'b0;
    step(3);
    chk("rst_req_valid", memReqValid, 0);
    chk("rst_wr_en", bufWrEn, 0);
    chk("rst_irq", irqDone, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill", fillLevel, 0);
    chk("rst_req_addr", memReqAddr, 0);
    chk("rst_wr_idx", bufWrIdx, 0);
    chk("rst_wr_data", bufWrData, 0);
    reset = 1'b1;
    step(2);

    // One-shot, three blocks, zero-wait memory.
    playIdx = 10'd5;
    w0 = wr_cnt;
    i0 = irq_cnt;
    push_run(32'h1000_0000, 3, 10'd5, 0, 3);
    start(32'h1000_0007, 16'd3, 1'b0);
    wait_wr("oneshot_timeout", w0 + 3, 100);
    step(4);
    chk("oneshot_irq_count", irq_cnt - i0, 1);
    chk("oneshot_busy", busy, 0);
    chk("oneshot_req_valid", memReqValid, 0);
    chk("oneshot_fill", fillLevel, 3);
    check_queues("oneshot");
    cfgEnable = 1'b0;
    step(2);

    // Reset while waiting for a response, then a stray response after release.
    playIdx  = 10'd7;
    mem_mute = 1'b1;
    r0 = req_cnt;
    exp_addr_q.push_back(32'h2000_0000);
    start(32'h2000_0000, 16'd4, 1'b0);
    wait_req("rstwait_timeout", r0 + 1, 50);
    step(1);
    chk("rstwait_pre_busy", busy, 1);
    reset     = 1'b0;
    cfgEnable = 1'b0;
    #1;
    chk("rstwait_req_valid", memReqValid, 0);
    chk("rstwait_wr_en", bufWrEn, 0);
    chk("rstwait_busy", busy, 0);
    chk("rstwait_req_addr", memReqAddr, 0);
    chk("rstwait_wr_idx", bufWrIdx, 0);
    chk("rstwait_wr_data", bufWrData, 0);
    chk("rstwait_fill", fillLevel, 0);
    chk("rstwait_irq", irqDone, 0);
    step(2);
    reset    = 1'b1;
    mem_mute = 1'b0;
    w0 = wr_cnt;
    step(1);
    inject_rsp = 1'b1;
    step(1);
    inject_rsp = 1'b0;
    step(4);
    chk("rstwait_late_rsp_writes", wr_cnt - w0, 0);
    chk("rstwait_idle_busy", busy, 0);
    chk("rstwait_idle_req", memReqValid, 0);
    check_queues("rstwait");

    // Looping two-block source until the guard gap stalls the refill.
    playIdx = 10'd100;
    w0 = wr_cnt;
    i0 = irq_cnt;
    r0 = req_cnt;
    push_run(32'h6000_0000, 2, 10'd100, 0, 1022);
    start(32'h6000_0000, 16'd2, 1'b1);
    wait_wr("loop_timeout", w0 + 1022, 6000);
    step(20);
    chk("loop_fill_stall", fillLevel, 1022);
    chk("loop_busy_stall", busy, 1);
    chk("loop_req_count", req_cnt - r0, 1022);
    chk("loop_irq_count", irq_cnt - i0, 511);
    chk("loop_req_valid_stall", memReqValid, 0);
    push_run(32'h6000_0000, 2, 10'd100, 1022, 1);
    playIdx = 10'd101;
    wait_wr("loop_resume_timeout", w0 + 1023, 50);
    step(10);
    chk("loop_fill_resume", fillLevel, 1022);
    cfgEnable = 1'b0;
    step(2);
    chk("loop_abort_busy", busy, 0);
    check_queues("loop");

    // Memory holds ready low for five cycles.
    playIdx   = 10'd20;
    stall_req = 5;
    w0 = wr_cnt;
    i0 = irq_cnt;
    r0 = req_cnt;
    push_run(32'h3000_0100, 1, 10'd20, 0, 1);
    start(32'h3000_0100, 16'd1, 1'b0);
    wait_wr("stall_timeout", w0 + 1, 100);
    step(4);
    stall_req = 0;
    chk("stall_valid_cycles", last_run, 6);
    chk("stall_req_count", req_cnt - r0, 1);
    chk("stall_wr_count", wr_cnt - w0, 1);
    chk("stall_irq_count", irq_cnt - i0, 1);
    check_queues("stall");
    cfgEnable = 1'b0;
    step(2);

    // Disable while the request is pending: block is fetched but dropped.
    playIdx   = 10'd30;
    stall_req = 3;
    w0 = wr_cnt;
    i0 = irq_cnt;
    r0 = req_cnt;
    exp_addr_q.push_back(32'h4000_0000);
    start(32'h4000_0000, 16'd2, 1'b0);
    bound = 20;
    while (!memReqValid && bound > 0) begin
      step(1);
      bound--;
    end
    chk("abort_saw_req", memReqValid, 1);
    cfgEnable = 1'b0;
    wait_req("abort_hs_timeout", r0 + 1, 20);
    stall_req = 0;
    step(6);
    chk("abort_writes", wr_cnt - w0, 0);
    chk("abort_irq", irq_cnt - i0, 0);
    chk("abort_busy", busy, 0);
    check_queues("abort");
    i0 = irq_cnt;
    push_run(32'h4000_0000, 2, 10'd30, 0, 2);
    start(32'h4000_0000, 16'd2, 1'b0);
    wait_wr("restart_timeout", w0 + 2, 100);
    step(3);
    chk("restart_irq", irq_cnt - i0, 1);
    chk("restart_busy", busy, 0);
    check_queues("restart");
    cfgEnable = 1'b0;
    step(2);

    // Zero-length source.
    i0 = irq_cnt;
    r0 = req_cnt;
    b0 = busy_cnt;
    start(32'h5000_0000, 16'd0, 1'b0);
    step(6);
    chk("len0_irq_count", irq_cnt - i0, 1);
    chk("len0_req_count", req_cnt - r0, 0);
    chk("len0_busy_cycles", busy_cnt - b0, 0);
    cfgEnable = 1'b0;
    step(2);
    check_queues("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aud_pcm_refill_ctl.md
Name: aud_pcm_refill_ctl

Overview:
Refill sequencer for the PCM sound device's 64-bit-block sample ring buffer. It tracks the fill level between its own write index and the device's current play index. When there is room, it fetches the next 64-bit block from main memory over a single-outstanding request/response port and writes it into the ring. It supports one-shot and looping sources and raises a completion/wrap pulse for the interrupt logic.

Parameters:
IDX_BITS, 10, ring index width; ring holds 2^IDX_BITS 64-bit blocks.
GUARD, 2, blocks kept empty ahead of the play index; must be >= 1.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cfgEnable  in  1  run enable; a 0->1 edge starts a transfer
cfgBaseAddr  in  32  source base byte address; bits [2:0] ignored (treated as 0)
cfgLenBlk  in  16  source length in 64-bit blocks
cfgLoop  in  1  1 = wrap source to base at end; 0 = stop at end
playIdx  in  IDX_BITS  block index currently being read by the PCM device
memReqAddr  out  32  block fetch address
memReqValid  out  1  fetch request valid
memReqReady  in  1  memory accepts the request this cycle
memRspData  in  64  fetched block
memRspValid  in  1  one-cycle response strobe
bufWrIdx  out  IDX_BITS  ring write index
bufWrData  out  64  ring write data
bufWrEn  out  1  ring write strobe, one cycle per block
irqDone  out  1  one-cycle pulse on source end (loop or stop)
busy  out  1  1 in any state other than IDLE and DONE
fillLevel  out  IDX_BITS  (wrIdx - playIdx) mod 2^IDX_BITS, registered

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE, wrIdx = 0, srcPos = 0, discard = 0, enable-edge register = 0. All outputs 0: memReqValid, bufWrEn, irqDone, busy, fillLevel, memReqAddr, bufWrIdx, bufWrData.
- States: IDLE, CHECK, REQ, WAIT, WRITE, DONE.
- IDLE: on a cfgEnable rising edge (registered previous value), latch base and len. Set srcPos = 0 and wrIdx = playIdx. If len == 0, go to DONE and pulse irqDone; else go to CHECK.
- CHECK: level = wrIdx - playIdx (mod 2^IDX_BITS). If level < 2^IDX_BITS - GUARD, go to REQ with memReqAddr = base + srcPos*8 (32-bit, wraps silently). Otherwise stay in CHECK.
- REQ: memReqValid = 1, held with stable memReqAddr until a cycle with memReqReady = 1. That cycle is the handshake; memReqValid drops next cycle and the state goes to WAIT. Exactly one request is outstanding at a time.
- WAIT: on memRspValid, capture memRspData and go to WRITE. memRspValid in any other state is ignored.
- WRITE: one cycle with bufWrEn = 1, bufWrIdx = wrIdx, bufWrData = captured data. Then wrIdx += 1 (wraps at 2^IDX_BITS) and srcPos += 1.
  - If the new srcPos == len and cfgLoop = 1: srcPos = 0, pulse irqDone, go to CHECK.
  - If the new srcPos == len and cfgLoop = 0: pulse irqDone, go to DONE.
  - Otherwise go to CHECK.
- DONE: idle, busy = 0. Return to IDLE when cfgEnable = 0.
- Latency: CHECK -> first memReqValid in 1 cycle. memRspValid -> bufWrEn in 1 cycle. Minimum block period is 4 cycles (CHECK, REQ, WAIT, WRITE) with zero-wait memory.
- Disable mid-operation (cfgEnable = 0):
  - In CHECK or DONE: go to IDLE next cycle.
  - In REQ: keep memReqValid until handshake, then go to WAIT with discard = 1.
  - In WAIT: set discard = 1.
  - When a response arrives with discard = 1: no buffer write, clear discard, go to IDLE.
  - In WRITE: the write completes, then go to IDLE.
  - irqDone never pulses on a discarded block.
- Config inputs other than cfgEnable are sampled only at start; changes mid-run have no effect.
- playIdx is sampled every cycle. A play index that overtakes wrIdx (underrun) is not detected; fillLevel simply wraps.
- fillLevel updates every cycle, including in IDLE.

Test Plan:
1. Reset low mid-WAIT -> all outputs 0 immediately; after release state is IDLE; a late memRspValid causes no bufWrEn.
2. Base 0x1000_0000, len 3, loop 0, playIdx 5, zero-wait memory -> memReqAddr 0x1000_0000, 0x1000_0008, 0x1000_0010; writes at idx 5, 6, 7; irqDone pulses once with the 3rd write; state DONE, busy 0.
3. Len 2, loop 1 -> addresses alternate 0x..00 / 0x..08; irqDone pulses every 2nd write; stalls in CHECK when fillLevel reaches 1022 with playIdx held (GUARD 2).
4. memReqReady held 0 for 5 cycles -> memReqValid and memReqAddr stable for 6 cycles; exactly one response is consumed.
5. cfgEnable dropped during REQ -> handshake completes, response discarded, no bufWrEn, no irqDone, state IDLE; re-enable restarts at srcPos 0.
6. Len 0 with enable edge -> irqDone single pulse, no memReqValid, busy stays 0.
